pll_lock_ctrl: RTL
==================

# pll_lock_ctrl

Reset/lock sequencer and dynamic-phase controller for the ECP5 EHXPLLL used by the clock_* generators. It runs on the PLL reference clock. It drives the PLL `RST` pin through a timed reset/wait/qualify sequence and declares the clock good only after `LOCK` has been stable. It re-runs the sequence on loss of lock or lock timeout, and serialises phase-step requests onto the PLL's `PHASESEL`/`PHASEDIR`/`PHASESTEP` pins.

## Interface
- `RST_CYCLES`, 16: clk_25m cycles `pll_rst` is held high per reset attempt (≥1)
- `LOCK_CYCLES`, 1024: consecutive synced-lock cycles required before `clk_ok` (≥1)
- `TIMEOUT_CYCLES`, 65536: cycles waiting for first lock before retrying reset (≥2)
- `STEP_CYCLES`, 4: width of the `pll_phasestep` low pulse, and of the settle gap after it (≥1)

Ports:
- `clk_25m` in 1: 25 MHz reference clock, the only clock
- `rst` in 1: synchronous, active-high reset
- `pll_locked` in 1: raw PLL `LOCK`, asynchronous; double-flop synchronised internally to `lock_s`
- `pll_rst` out 1: to PLL `RST`
- `pll_phasesel` out 2: to `PHASESEL1:0`
- `pll_phasedir` out 1: to `PHASEDIR`
- `pll_phasestep` out 1: to `PHASESTEP`, idle high
- `step_req` in 1: phase-step request, level, held until `step_ack`
- `step_sel` in 2: output select, sampled with `step_req`
- `step_dir` in 1: direction, sampled with `step_req`
- `step_ack` out 1: one-cycle completion pulse
- `clk_ok` out 1: PLL outputs qualified
- `relock_count` out 8: loss-of-lock events, saturating at 255

## Operation
- States:
  - RESET: `pll_rst`=1. Count `RST_CYCLES` cycles, then go to WAIT.
  - WAIT: `pll_rst`=0.
    - `lock_s`=1 → QUAL, counter cleared.
    - `TIMEOUT_CYCLES` cycles without lock → RESET.
  - QUAL: count consecutive `lock_s`=1 cycles.
    - `lock_s`=0 → RESET.
    - Count reaches `LOCK_CYCLES` → RUN.
  - RUN: `clk_ok`=1.
    - `lock_s`=0 → RESET and `relock_count`+1 (saturating). This takes priority over `step_req`.
    - `step_req`=1 → SETUP.
  - SETUP (1 cycle): latch `step_sel` into `pll_phasesel` and `step_dir` into `pll_phasedir`.
  - PULSE: `pll_phasestep`=0 for `STEP_CYCLES` cycles.
  - SETTLE: `pll_phasestep`=1 for `STEP_CYCLES` cycles.
  - ACK (1 cycle): `step_ack`=1, then RUN.
- Loss of lock during SETUP/PULSE/SETTLE/ACK:
  - Go to RESET and increment `relock_count`.
  - `pll_phasestep` returns to 1 next cycle.
  - No `step_ack` is issued.
- `clk_ok`=1 in RUN and in every step state; 0 in all others.
- `pll_phasesel`/`pll_phasedir` hold their last latched values outside SETUP.
- Outside RUN, `step_req` is not accepted. It remains pending and is served on entry to RUN.
- The requester drops `step_req` in the cycle after `step_ack`. If `step_req` is still high, it is a new request.
- Timeout in WAIT does not change `relock_count`.

## Timing
- Reset values while `rst`=1 (registered):
  - state RESET, counter 0
  - `pll_rst`=1, `pll_phasestep`=1
  - `pll_phasesel`=0, `pll_phasedir`=0
  - `step_ack`=0, `clk_ok`=0, `relock_count`=0
- `rst` asserted at any time (including mid-step) forces the above on the next edge.
- After `rst` falls, `pll_rst` stays high exactly `RST_CYCLES` more cycles.
- `lock_s` lags `pll_locked` by 2 cycles.
- `clk_ok` rises `LOCK_CYCLES` cycles after the first cycle `lock_s`=1 in WAIT.
- `lock_s` falling in RUN: `clk_ok` falls and `pll_rst` rises on the next edge.
- Step latency: if the edge sampling `step_req` is cycle 0:
  - SETUP in cycle 1
  - `pll_phasestep` low cycles 2..1+S
  - `step_ack` high in cycle 2+2S (S = `STEP_CYCLES`)
- Counters are sized to `$clog2` of the largest parameter + 1. There is no wrap in any state.

## Test plan
Parameters for all scenarios: `RST_CYCLES`=4, `LOCK_CYCLES`=8, `TIMEOUT_CYCLES`=32, `STEP_CYCLES`=2.

1. Release `rst`, drive `pll_locked`=1 from cycle 6 → `pll_rst` high cycles 1–4; `clk_ok` rises 8 cycles after `lock_s` first high; `relock_count`=0.
2. Hold `pll_locked`=0 → `pll_rst` re-pulses 4 cycles every 36 cycles; `clk_ok` stays 0; `relock_count` stays 0.
3. In RUN, pulse `pll_locked` low 1 cycle → `clk_ok` falls, full reset sequence runs, `relock_count`=1; repeat 300 times → saturates at 255.
4. In RUN, `step_req`=1, `step_sel`=2, `step_dir`=1 → `pll_phasesel`=2 and `pll_phasedir`=1 from cycle 1; `pll_phasestep` low cycles 2–3; `step_ack` one pulse at cycle 6.
5. Drop lock during PULSE → `pll_phasestep`=1 next cycle, no `step_ack`, RESET, `relock_count`+1; with `step_req` held, the step completes after re-qualification.
6. Glitch `pll_locked` low during QUAL (count 5) → RESET, `clk_ok` never asserted, `relock_count` unchanged; assert `rst` mid-step → all outputs return to reset values next edge.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// EHXPLLL reset/lock sequencer and phase-step serialiser on the 25 MHz reference; all outputs registered.
// Latency: clk_ok LOCK_CYCLES after first synced lock; step_ack 2+2*STEP_CYCLES after step_req is sampled; step_req held until step_ack.
module pll_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STEP_CYCLES    = 4
) (
    input  logic       clk_25m,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    input  logic       step_req,
    input  logic [1:0] step_sel,
    input  logic       step_dir,
    output logic       step_ack,
    output logic       clk_ok,
    output logic [7:0] relock_count
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
    localparam int MAX_CD = (TIMEOUT_CYCLES > STEP_CYCLES) ? TIMEOUT_CYCLES : STEP_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    // The WAIT cycle that first sees lock already counts towards qualification.
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'((LOCK_CYCLES > 1) ? (LOCK_CYCLES - 2) : 0);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT,
        S_QUAL,
        S_RUN,
        S_SETUP,
        S_PULSE,
        S_SETTLE,
        S_ACK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;
    logic             clk_good_state;

    assign clk_good_state = (state == S_RUN) || (state == S_SETUP) || (state == S_PULSE) ||
                            (state == S_SETTLE) || (state == S_ACK);

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state         <= S_RESET;
            cnt           <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            pll_rst       <= 1'b1;
            pll_phasestep <= 1'b1;
            pll_phasesel  <= 2'd0;
            pll_phasedir  <= 1'b0;
            step_ack      <= 1'b0;
            clk_ok        <= 1'b0;
            relock_count  <= 8'd0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            step_ack  <= 1'b0;

            if (clk_good_state && !lock_s) begin
                // Loss of lock wins over any pending or in-flight step.
                state         <= S_RESET;
                cnt           <= '0;
                pll_rst       <= 1'b1;
                pll_phasestep <= 1'b1;
                clk_ok        <= 1'b0;
                if (relock_count != 8'hFF)
                    relock_count <= relock_count + 8'd1;
            end else begin
                case (state)
                    S_RESET: begin
                        if (cnt == RST_LAST) begin
                            state   <= S_WAIT;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_WAIT: begin
                        if (lock_s) begin
                            cnt <= '0;
                            if (LOCK_CYCLES == 1) begin
                                state  <= S_RUN;
                                clk_ok <= 1'b1;
                            end else begin
                                state <= S_QUAL;
                            end
                        end else if (cnt == TMO_LAST) begin
                            state   <= S_RESET;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_QUAL: begin
                        if (!lock_s) begin
                            state   <= S_RESET;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                        end else if (cnt == QUAL_LAST) begin
                            state  <= S_RUN;
                            cnt    <= '0;
                            clk_ok <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_RUN: begin
                        if (step_req) begin
                            state        <= S_SETUP;
                            cnt          <= '0;
                            pll_phasesel <= step_sel;
                            pll_phasedir <= step_dir;
                        end
                    end
                    S_SETUP: begin
                        state         <= S_PULSE;
                        cnt           <= '0;
                        pll_phasestep <= 1'b0;
                    end
                    S_PULSE: begin
                        if (cnt == STEP_LAST) begin
                            state         <= S_SETTLE;
                            cnt           <= '0;
                            pll_phasestep <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == STEP_LAST) begin
                            state    <= S_ACK;
                            cnt      <= '0;
                            step_ack <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    S_ACK: begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                    default: begin
                        state         <= S_RESET;
                        cnt           <= '0;
                        pll_rst       <= 1'b1;
                        pll_phasestep <= 1'b1;
                        clk_ok        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
